// File: rtl/mv_draw_pkg.sv
// Shared constants and types for the sprite drawer and the jobs that feed it.
package mv_draw_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam int DRAW_XW = 9;
  localparam int DRAW_YW = 8;
  localparam int DRAW_SW = 3;

  localparam logic [DRAW_SW-1:0] SPR_BG       = 3'd0;
  localparam logic [DRAW_SW-1:0] SPR_CHAR     = 3'd1;
  localparam logic [DRAW_SW-1:0] SPR_PLATFORM = 3'd2;
  localparam logic [DRAW_SW-1:0] SPR_BUTTON   = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after last+1, wrapping.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] win_oh,
  output logic [IW-1:0]    win_idx,
  output logic             win_valid
);

  localparam int NP = 1 << IW;

  // Padding to a power of two keeps every candidate index in range.
  logic [NP-1:0] req_pad;
  assign req_pad = NP'(req);

  always_comb begin
    logic [IW:0] cand;
    cand      = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = {1'b0, last} + (IW+1)'(off);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (!win_valid && req_pad[cand[IW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_oh
    assign win_oh[gi] = win_valid && (win_idx == IW'(gi));
  end

endmodule

// File: rtl/sprite_draw_arbiter.sv
// Round-robin arbiter that owns the single sprite drawer: latches one job,
// starts the drawer, waits for completion or watchdog, then signals the owner.
module sprite_draw_arbiter
  import mv_draw_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int XW      = DRAW_XW,
  parameter int YW      = DRAW_YW,
  parameter int SW      = DRAW_SW,
  parameter int TIMEOUT = 100000
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*XW-1:0]         req_x,
  input  logic [N_REQ*YW-1:0]         req_y,
  input  logic [N_REQ*SW-1:0]         req_sprite,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            done,
  output logic                        draw_start,
  output logic [XW-1:0]               draw_x,
  output logic [YW-1:0]               draw_y,
  output logic [SW-1:0]               draw_sprite,
  input  logic                        drawer_done,
  output logic                        err_timeout,
  output logic [$clog2(N_REQ)-1:0]    err_id
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e        state_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  done_q;
  logic              start_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [SW-1:0]     spr_q;
  logic              err_q;
  logic [IW-1:0]     err_id_q;
  logic [IW-1:0]     last_q;
  logic [IW-1:0]     owner_q;
  logic [CW-1:0]     cnt_q;

  logic [N_REQ-1:0]  win_oh;
  logic [IW-1:0]     win_idx;
  logic              win_valid;

  logic [XW-1:0]     x_arr   [N_REQ];
  logic [YW-1:0]     y_arr   [N_REQ];
  logic [SW-1:0]     spr_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign x_arr[gi]   = req_x[gi*XW +: XW];
    assign y_arr[gi]   = req_y[gi*YW +: YW];
    assign spr_arr[gi] = req_sprite[gi*SW +: SW];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req       (req),
    .last      (last_q),
    .win_oh    (win_oh),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      spr_q    <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
      last_q   <= IW'(N_REQ - 1);
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            gnt_q   <= win_oh;
            owner_q <= win_idx;
            last_q  <= win_idx;
            x_q     <= x_arr[win_idx];
            y_q     <= y_arr[win_idx];
            spr_q   <= spr_arr[win_idx];
            start_q <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          // A drawer completion wins over a coincident watchdog expiry.
          if (drawer_done) begin
            done_q  <= gnt_q;
            state_q <= ST_RELEASE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_q    <= 1'b1;
            err_id_q <= owner_q;
            done_q   <= gnt_q;
            state_q  <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign draw_start  = start_q;
  assign draw_x      = x_q;
  assign draw_y      = y_q;
  assign draw_sprite = spr_q;
  assign err_timeout = err_q;
  assign err_id      = err_id_q;

endmodule

// File: doc/sprite_draw_arbiter.md
# sprite_draw_arbiter

Shares the single sprite/background drawer between several requesters: the character mover, platform animator and button/door animator. Each requester posts a draw job with sprite id and coordinates. The arbiter picks one by round-robin, latches its operands and issues a one-cycle start to the drawer. It then waits for the drawer's done pulse, or a watchdog timeout, and returns a one-cycle done to the owner.

## Interface
- N_REQ, 3: number of requesters (2..8).
- XW, 9: x coordinate width (320-wide screen).
- YW, 8: y coordinate width (240-high screen).
- SW, 3: sprite id width.
- TIMEOUT, 100000: max cycles in WAIT before abort; must be ≥ 320·240 + margin.
- clock  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- req  in  N_REQ  level request, one bit per requester.
- req_x  in  N_REQ·XW  packed x; requester i uses bits [i·XW +: XW].
- req_y  in  N_REQ·YW  packed y, same packing.
- req_sprite  in  N_REQ·SW  packed sprite id, same packing.
- gnt  out  N_REQ  one-hot owner, held from ISSUE through RELEASE.
- done  out  N_REQ  one-cycle pulse to the owner when its job ends.
- draw_start  out  1  one-cycle start to drawer.
- draw_x / draw_y / draw_sprite  out  XW / YW / SW  latched operands, stable from ISSUE until the next grant.
- drawer_done  in  1  one-cycle completion pulse from drawer.
- err_timeout  out  1  sticky; set on watchdog abort.
- err_id  out  clog2(N_REQ)  requester index of the last aborted job.

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE: if any req bit is set, pick the winner by round-robin, scanning from (last+1) mod N_REQ upward. Latch that requester's x/y/sprite into draw_*, set gnt, set last=winner, go to ISSUE. With no request, stay in IDLE.
- ISSUE: draw_start=1 for exactly one cycle. Clear the watchdog counter. Go to WAIT.
- WAIT: counter increments each cycle.
  - If drawer_done=1, go to RELEASE.
  - Otherwise, if counter == TIMEOUT-1, set err_timeout=1 and err_id=owner, then go to RELEASE.
  - drawer_done and timeout in the same cycle: treated as normal completion, no error.
- RELEASE: done[owner]=1 for one cycle. Go to IDLE. gnt clears on the exit edge.
- Requester rule:
  - Hold req and operands stable until done is seen.
  - Deassert req on the edge that ends the done cycle.
  - A req still high in the following IDLE cycle is treated as a new job.
- Round-robin: `last` resets to N_REQ-1, so requester 0 wins the first contention. No requester waits more than N_REQ-1 jobs.
- drawer_done outside WAIT is ignored.
- req changes outside IDLE are ignored; operands are already latched.
- Counter width: clog2(TIMEOUT+1). It never wraps; it saturates via the abort.

## Timing
- Reset values: state=IDLE, gnt=0, done=0, draw_start=0, draw_x/y/sprite=0, err_timeout=0, err_id=0, last=N_REQ-1, counter=0.
- Reset mid-job abandons the job immediately, with no done pulse. The drawer shares resetn.
- Cycle numbering: req sampled high in IDLE at edge k.
  - gnt and draw_* valid from k+1.
  - draw_start high during the cycle after k (ISSUE).
  - drawer_done at edge m (m ≥ k+2) gives done high during the cycle after m.
- Minimum turnaround: 4 cycles per job plus drawer latency.
- Back-to-back: next grant is taken at the IDLE edge directly after RELEASE.
- Timeout abort: done asserted TIMEOUT+1 cycles after draw_start.

## Structure
- Shared package `mv_draw_pkg`:
  - screen constants SCREEN_W=320, SCREEN_H=240.
  - XW/YW/SW widths.
  - sprite id constants: SPR_BG, SPR_CHAR, SPR_PLATFORM, SPR_BUTTON.
  - arbiter state encoding.
- One sub-module: `rr_pick`. It is combinational: it takes the req vector and `last` and returns the one-hot winner and its index.
- FSM, latches and watchdog live in the top.

## Test plan
- Single job:
  - Stimulus: req=001, x=95, y=221, sprite=SPR_CHAR; drawer_done 10 cycles after start.
  - Required: draw_start is one cycle, draw_x=95, draw_y=221, done=001 for one cycle, gnt=000 afterwards.
- Contention:
  - Stimulus: req=111 held, each requester re-asserting after its done.
  - Required: grant order 0,1,2,0,1,2.
- Simultaneous drawer_done and timeout:
  - Stimulus: TIMEOUT=16, drawer_done arrives in the same cycle as the timeout.
  - Required: done pulses, err_timeout stays 0.
- Timeout abort:
  - Stimulus: TIMEOUT=16, requester 2 granted, drawer never answers.
  - Required: done=100 exactly 17 cycles after draw_start, err_timeout=1, err_id=2, and the arbiter serves the next req normally.
- Reset mid-WAIT:
  - Stimulus: resetn=0 for one cycle while in WAIT.
  - Required: all outputs return to reset values, no done pulse, next req=010 is granted first.
- Stray drawer_done and operand changes:
  - Stimulus: drawer_done pulsed in IDLE; req_x changed during WAIT.
  - Required: no state change from the stray done, and draw_x keeps the latched value.
